// File: rtl/clk_ratio_monitor.sv
// clk_ratio_monitor
// Measures the period and the high-phase length of a divided clock in units of
// reference-clock cycles. The monitored clock is only ever treated as data: it
// is synchronised and scanned for rising edges. Two identical consecutive
// (period, high) measurements establish lock. A missing edge for 2^WIDTH-1
// cycles reports a timeout.
//
// Output qualification: o_valid is a level, not a handshake. While o_valid=1,
// o_ratio/o_high carry the locked measurement. While o_valid=0 they read zero.
// There is no ready input, so the consumer samples the outputs whenever it likes.
// o_change is a single-cycle pulse on the cycle where a lock is lost because a
// different measurement arrived.
module clk_ratio_monitor #(
  parameter int WIDTH = 8
) (
  input  logic             i_ref_clk,
  input  logic             i_rst_n,
  input  logic             i_mon_clk,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_ratio,
  output logic [WIDTH-1:0] o_high,
  output logic             o_valid,
  output logic             o_change,
  output logic             o_timeout,
  output logic [2:0]       o_dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACQUIRE = 3'd1,
    ST_MEASURE = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  // Synchroniser and edge detector
  logic             r_sync_q1;
  logic             r_sync_s;
  logic             r_sync_d;
  logic             w_rise;

  // FSM and measurement counters
  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_hcnt;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_hcnt_nxt;
  logic             w_cnt_sat;
  logic             w_hcnt_sat;

  // Stored (period, high) pair from the most recent capture
  logic [WIDTH-1:0] r_pair_p;
  logic [WIDTH-1:0] r_pair_h;
  logic             r_pair_ok;
  logic [WIDTH-1:0] w_pair_p_nxt;
  logic [WIDTH-1:0] w_pair_h_nxt;
  logic             w_pair_ok_nxt;
  logic             w_match;

  // Registered outputs
  logic [WIDTH-1:0] r_ratio;
  logic [WIDTH-1:0] r_high;
  logic             r_valid;
  logic             r_change;
  logic             r_timeout;
  logic [WIDTH-1:0] w_ratio_nxt;
  logic [WIDTH-1:0] w_high_nxt;
  logic             w_valid_nxt;
  logic             w_change_nxt;
  logic             w_timeout_nxt;

  // Two-flop synchroniser followed by one delay flop for edge detection
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync_q1 <= 1'b0;
      r_sync_s  <= 1'b0;
      r_sync_d  <= 1'b0;
    end else begin
      r_sync_q1 <= i_mon_clk;
      r_sync_s  <= r_sync_q1;
      r_sync_d  <= r_sync_s;
    end
  end

  assign w_rise     = r_sync_s & ~r_sync_d;
  assign w_cnt_sat  = (r_cnt == CNT_MAX);
  assign w_hcnt_sat = (r_hcnt == CNT_MAX);

  // The pre-load counter values are the capture; compare them to the stored pair
  assign w_match = r_pair_ok && (r_cnt == r_pair_p) && (r_hcnt == r_pair_h);

  // Period and high counters: restart at 1 on every rise, saturate instead of wrapping
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_hcnt_nxt = r_hcnt;
    if (!i_en || (r_state == ST_IDLE)) begin
      w_cnt_nxt  = '0;
      w_hcnt_nxt = '0;
    end else if (w_rise) begin
      w_cnt_nxt  = CNT_ONE;
      w_hcnt_nxt = CNT_ONE;
    end else begin
      if (!w_cnt_sat) begin
        w_cnt_nxt = r_cnt + CNT_ONE;
      end
      if (r_sync_s && !w_hcnt_sat) begin
        w_hcnt_nxt = r_hcnt + CNT_ONE;
      end
    end
  end

  // Next-state, stored pair and next output values; a rise always beats saturation
  always_comb begin
    w_state_nxt   = r_state;
    w_pair_p_nxt  = r_pair_p;
    w_pair_h_nxt  = r_pair_h;
    w_pair_ok_nxt = r_pair_ok;
    w_change_nxt  = 1'b0;

    if (!i_en) begin
      w_state_nxt   = ST_IDLE;
      w_pair_p_nxt  = '0;
      w_pair_h_nxt  = '0;
      w_pair_ok_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt   = ST_ACQUIRE;
          w_pair_p_nxt  = '0;
          w_pair_h_nxt  = '0;
          w_pair_ok_nxt = 1'b0;
        end
        ST_ACQUIRE: begin
          // The first rise only opens a period; nothing is captured yet
          if (w_rise) begin
            w_state_nxt = ST_MEASURE;
          end else if (w_cnt_sat) begin
            w_state_nxt = ST_TIMEOUT;
          end
        end
        ST_MEASURE: begin
          if (w_rise) begin
            w_pair_p_nxt  = r_cnt;
            w_pair_h_nxt  = r_hcnt;
            w_pair_ok_nxt = 1'b1;
            if (w_match) begin
              w_state_nxt = ST_LOCKED;
            end
          end else if (w_cnt_sat) begin
            w_state_nxt   = ST_TIMEOUT;
            w_pair_p_nxt  = '0;
            w_pair_h_nxt  = '0;
            w_pair_ok_nxt = 1'b0;
          end
        end
        ST_LOCKED: begin
          if (w_rise) begin
            if (!w_match) begin
              w_pair_p_nxt  = r_cnt;
              w_pair_h_nxt  = r_hcnt;
              w_pair_ok_nxt = 1'b1;
              w_change_nxt  = 1'b1;
              w_state_nxt   = ST_MEASURE;
            end
          end else if (w_cnt_sat) begin
            w_state_nxt   = ST_TIMEOUT;
            w_pair_p_nxt  = '0;
            w_pair_h_nxt  = '0;
            w_pair_ok_nxt = 1'b0;
          end
        end
        ST_TIMEOUT: begin
          // The recovering rise starts a fresh period, like the first rise in ACQUIRE
          if (w_rise) begin
            w_state_nxt = ST_MEASURE;
          end
        end
        default: begin
          w_state_nxt   = ST_IDLE;
          w_pair_p_nxt  = '0;
          w_pair_h_nxt  = '0;
          w_pair_ok_nxt = 1'b0;
        end
      endcase
    end

    w_valid_nxt   = (w_state_nxt == ST_LOCKED);
    w_timeout_nxt = (w_state_nxt == ST_TIMEOUT);
    w_ratio_nxt   = w_valid_nxt ? w_pair_p_nxt : '0;
    w_high_nxt    = w_valid_nxt ? w_pair_h_nxt : '0;
  end

  // State register
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counter and stored-pair registers
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_hcnt    <= '0;
      r_pair_p  <= '0;
      r_pair_h  <= '0;
      r_pair_ok <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_hcnt    <= w_hcnt_nxt;
      r_pair_p  <= w_pair_p_nxt;
      r_pair_h  <= w_pair_h_nxt;
      r_pair_ok <= w_pair_ok_nxt;
    end
  end

  // Output registers
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ratio   <= '0;
      r_high    <= '0;
      r_valid   <= 1'b0;
      r_change  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_ratio   <= w_ratio_nxt;
      r_high    <= w_high_nxt;
      r_valid   <= w_valid_nxt;
      r_change  <= w_change_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign o_ratio     = r_ratio;
  assign o_high      = r_high;
  assign o_valid     = r_valid;
  assign o_change    = r_change;
  assign o_timeout   = r_timeout;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// tb_clk_ratio_monitor
// Drives generated divided-clock waveforms into clk_ratio_monitor. An
// event-level reference model predicts every output on every cycle. The model
// keeps edge timestamps, the sampled level history since the last edge, and the
// list of captured (period, high) pairs. Lock means the last two captures
// agree.
module tb_clk_ratio_monitor;

  localparam int W    = 8;
  localparam int MAXC = (1 << W) - 1;
  localparam int OW   = 2 * W + 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         en = 1'b0;
  logic         tie = 1'b0;
  logic         mon_drv = 1'b0;
  logic         mon;
  logic [W-1:0] o_ratio;
  logic [W-1:0] o_high;
  logic         o_valid;
  logic         o_change;
  logic         o_timeout;
  logic [2:0]   o_dbg_state;

  int n_checks = 0;
  int n_errs   = 0;

  // clock / reset
  always #5 clk = ~clk;

  assign mon = tie ? clk : mon_drv;

  clk_ratio_monitor #(.WIDTH(W)) dut (
    .i_ref_clk   (clk),
    .i_rst_n     (rst_n),
    .i_mon_clk   (mon),
    .i_en        (en),
    .o_ratio     (o_ratio),
    .o_high      (o_high),
    .o_valid     (o_valid),
    .o_change    (o_change),
    .o_timeout   (o_timeout),
    .o_dbg_state (o_dbg_state)
  );

  // waveform generator state
  bit gen_periodic = 1'b0;
  bit gen_level    = 1'b0;
  int gen_per      = 2;
  int gen_high     = 1;
  int gen_ph       = 0;

  // reference model state
  bit   md_s1, md_s, md_sd;
  bit   md_idle, md_started, md_to;
  int   md_k, md_r;
  int   cap_p[$];
  int   cap_h[$];
  bit   s_hist[$];
  logic         exp_valid, exp_change, exp_to;
  logic [W-1:0] exp_ratio, exp_high;

  function automatic bit md_locked();
    if (cap_p.size() < 2) return 1'b0;
    return (cap_p[$] == cap_p[$-1]) && (cap_h[$] == cap_h[$-1]);
  endfunction

  function automatic void md_clear_caps();
    cap_p.delete();
    cap_h.delete();
  endfunction

  function automatic void model_reset();
    md_s1 = 0; md_s = 0; md_sd = 0;
    md_idle = 1; md_started = 0; md_to = 0;
    md_k = 0; md_r = 0;
    md_clear_caps();
    s_hist.delete();
    exp_valid = 0; exp_change = 0; exp_to = 0;
    exp_ratio = '0; exp_high = '0;
  endfunction

  // Predict the outputs after the coming edge, given the inputs sampled there.
  function automatic void model_edge(input bit en_in, input bit mon_in);
    bit rise;
    bit was;
    int p;
    int h;
    rise = md_s && !md_sd;
    exp_change = 1'b0;
    if (!en_in) begin
      md_idle = 1; md_started = 0; md_to = 0;
      md_clear_caps();
      s_hist.delete();
    end else if (md_idle) begin
      md_idle = 0; md_started = 0; md_to = 0;
      md_r = md_k + 1;
      md_clear_caps();
      s_hist.delete();
    end else begin
      if (rise) begin
        if (md_started && !md_to) begin
          p = md_k - md_r;
          h = 0;
          foreach (s_hist[i]) h += int'(s_hist[i]);
          was = md_locked();
          cap_p.push_back(p);
          cap_h.push_back(h);
          if (was && !md_locked()) exp_change = 1'b1;
        end else begin
          md_started = 1;
          md_to = 0;
          md_clear_caps();
        end
        md_r = md_k;
        s_hist.delete();
      end else if (!md_to && (md_k - md_r >= MAXC)) begin
        md_to = 1;
        md_clear_caps();
      end
      s_hist.push_back(md_s);
    end
    exp_valid = md_locked();
    exp_to    = md_to;
    exp_ratio = '0;
    exp_high  = '0;
    if (exp_valid) begin
      exp_ratio = W'(cap_p[$]);
      exp_high  = W'(cap_h[$]);
    end
    md_k++;
    md_sd = md_s;
    md_s  = md_s1;
    md_s1 = mon_in;
  endfunction

  function automatic logic [OW-1:0] got_vec();
    return {o_valid, o_change, o_timeout, o_ratio, o_high};
  endfunction

  function automatic logic [OW-1:0] exp_vec();
    return {exp_valid, exp_change, exp_to, exp_ratio, exp_high};
  endfunction

  // driver: one reference cycle; called at a negedge, returns at the next negedge
  task automatic step();
    bit m;
    if (gen_periodic) begin
      m = (gen_ph < gen_high);
      gen_ph++;
      if (gen_ph >= gen_per) gen_ph = 0;
    end else begin
      m = gen_level;
    end
    mon_drv = m;
    model_edge(en, m);
    @(negedge clk);
  endtask

  task automatic start_clock(input int per, input int high);
    gen_periodic = 1'b1;
    gen_per = per;
    gen_high = high;
    gen_ph = 0;
  endtask

  task automatic go_idle(input int n);
    en = 1'b0;
    gen_periodic = 1'b0;
    gen_level = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (got_vec() !== '0) begin
      n_errs++;
      $display("FAIL reset_values got=%h exp=0", got_vec());
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (got_vec() !== exp_vec()) begin
        n_errs++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_lock_basic();
    int lock_at;
    lock_at = -1;
    go_idle(4);
    en = 1'b1;
    start_clock(4, 2);
    for (int i = 1; i <= 40; i++) begin
      step();
      n_checks++;
      if (got_vec() !== exp_vec()) begin
        n_errs++;
        $display("FAIL lock4_cycle cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
      end
      if (o_valid === 1'b1 && lock_at < 0) lock_at = i;
    end
    n_checks++;
    if (lock_at != 2 * 4 + 3) begin
      n_errs++;
      $display("FAIL lock4_latency got=%0d exp=%0d", lock_at, 2 * 4 + 3);
    end
    n_checks++;
    if ({o_valid, o_timeout, o_ratio, o_high} !== {1'b1, 1'b0, 8'd4, 8'd2}) begin
      n_errs++;
      $display("FAIL lock4_values valid=%b to=%b ratio=%0d high=%0d exp 1/0/4/2",
               o_valid, o_timeout, o_ratio, o_high);
    end
  endtask

  task automatic test_ratio_switch();
    int changes;
    changes = 0;
    go_idle(4);
    en = 1'b1;
    start_clock(5, 3);
    for (int i = 0; i < 30; i++) begin
      step();
      n_checks++;
      if (got_vec() !== exp_vec()) begin
        n_errs++;
        $display("FAIL ratio5_cycle cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
      end
    end
    n_checks++;
    if ({o_valid, o_ratio, o_high} !== {1'b1, 8'd5, 8'd3}) begin
      n_errs++;
      $display("FAIL ratio5_values valid=%b ratio=%0d high=%0d exp 1/5/3", o_valid, o_ratio, o_high);
    end
    for (int i = 0; i < 6 && gen_ph != 0; i++) step();
    gen_per = 8;
    gen_high = 4;
    for (int i = 0; i < 50; i++) begin
      step();
      n_checks++;
      if (got_vec() !== exp_vec()) begin
        n_errs++;
        $display("FAIL switch8_cycle cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
      end
      if (o_change === 1'b1) changes++;
    end
    n_checks++;
    if (changes != 1) begin
      n_errs++;
      $display("FAIL switch_change_count got=%0d exp=1", changes);
    end
    n_checks++;
    if ({o_valid, o_ratio, o_high} !== {1'b1, 8'd8, 8'd4}) begin
      n_errs++;
      $display("FAIL ratio8_values valid=%b ratio=%0d high=%0d exp 1/8/4", o_valid, o_ratio, o_high);
    end
  endtask

  task automatic test_timeout_recover();
    int to_at;
    int clr_at;
    int lock_at;
    to_at = -1;
    clr_at = -1;
    lock_at = -1;
    go_idle(4);
    en = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      step();
      n_checks++;
      if (got_vec() !== exp_vec()) begin
        n_errs++;
        $display("FAIL stuck_cycle cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
      end
      if (o_timeout === 1'b1 && to_at < 0) to_at = i;
    end
    n_checks++;
    if (to_at != MAXC + 2) begin
      n_errs++;
      $display("FAIL timeout_latency got=%0d exp=%0d", to_at, MAXC + 2);
    end
    n_checks++;
    if ({o_valid, o_ratio, o_high} !== '0) begin
      n_errs++;
      $display("FAIL timeout_outputs valid=%b ratio=%0d high=%0d exp 0", o_valid, o_ratio, o_high);
    end
    start_clock(6, 3);
    for (int i = 1; i <= 40; i++) begin
      step();
      n_checks++;
      if (got_vec() !== exp_vec()) begin
        n_errs++;
        $display("FAIL recover6_cycle cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
      end
      if (o_timeout === 1'b0 && clr_at < 0) clr_at = i;
      if (o_valid === 1'b1 && lock_at < 0) lock_at = i;
    end
    n_checks++;
    if (clr_at != 3 || lock_at != 2 * 6 + 3) begin
      n_errs++;
      $display("FAIL recover_latency clear=%0d lock=%0d exp 3/15", clr_at, lock_at);
    end
    n_checks++;
    if ({o_valid, o_ratio, o_high} !== {1'b1, 8'd6, 8'd3}) begin
      n_errs++;
      $display("FAIL ratio6_values valid=%b ratio=%0d high=%0d exp 1/6/3", o_valid, o_ratio, o_high);
    end
  endtask

  task automatic test_boundary();
    int lock_at;
    int to_cycles;
    int valid_cycles;
    lock_at = -1;
    to_cycles = 0;
    valid_cycles = 0;
    go_idle(4);
    en = 1'b1;
    start_clock(MAXC, 128);
    for (int i = 1; i <= 2 * MAXC + 10; i++) begin
      step();
      n_checks++;
      if (got_vec() !== exp_vec()) begin
        n_errs++;
        $display("FAIL period255_cycle cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
      end
      if (o_valid === 1'b1 && lock_at < 0) lock_at = i;
    end
    n_checks++;
    if (lock_at != 2 * MAXC + 3 || o_ratio !== 8'd255 || o_high !== 8'd128) begin
      n_errs++;
      $display("FAIL period255_lock at=%0d ratio=%0d high=%0d exp %0d/255/128",
               lock_at, o_ratio, o_high, 2 * MAXC + 3);
    end
    for (int i = 0; i < MAXC + 1 && gen_ph != 0; i++) step();
    gen_per = MAXC + 1;
    for (int i = 1; i <= 800; i++) begin
      step();
      n_checks++;
      if (got_vec() !== exp_vec()) begin
        n_errs++;
        $display("FAIL period256_cycle cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
      end
      if (o_timeout === 1'b1) to_cycles++;
      if (i > 300 && o_valid === 1'b1) valid_cycles++;
    end
    n_checks++;
    if (to_cycles == 0 || valid_cycles != 0) begin
      n_errs++;
      $display("FAIL period256_timeout to_cycles=%0d late_valid=%0d exp >0/0", to_cycles, valid_cycles);
    end
  endtask

  task automatic test_bypass();
    en = 1'b0;
    gen_periodic = 1'b0;
    gen_level = 1'b0;
    do_reset();
    tie = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 300; i++) step();
    n_checks++;
    if ({o_timeout, o_valid, o_ratio, o_high} !== {1'b1, 1'b0, 16'd0}) begin
      n_errs++;
      $display("FAIL bypass_timeout to=%b valid=%b ratio=%0d high=%0d exp 1/0/0/0",
               o_timeout, o_valid, o_ratio, o_high);
    end
    tie = 1'b0;
    en = 1'b0;
    do_reset();
  endtask

  task automatic test_reset_mid();
    int lock_at;
    lock_at = -1;
    go_idle(4);
    en = 1'b1;
    start_clock(4, 2);
    for (int i = 0; i < 20; i++) begin
      step();
      n_checks++;
      if (got_vec() !== exp_vec()) begin
        n_errs++;
        $display("FAIL prereset_cycle cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
      end
    end
    n_checks++;
    if (o_valid !== 1'b1) begin
      n_errs++;
      $display("FAIL prereset_lock valid=%b exp 1", o_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (got_vec() !== '0) begin
      n_errs++;
      $display("FAIL async_reset got=%h exp=0", got_vec());
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    start_clock(4, 2);
    for (int i = 1; i <= 30; i++) begin
      step();
      n_checks++;
      if (got_vec() !== exp_vec()) begin
        n_errs++;
        $display("FAIL relock_cycle cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
      end
      if (o_valid === 1'b1 && lock_at < 0) lock_at = i;
    end
    n_checks++;
    if (lock_at != 2 * 4 + 3) begin
      n_errs++;
      $display("FAIL relock_latency got=%0d exp=%0d", lock_at, 2 * 4 + 3);
    end
  endtask

  task automatic test_enable_drop();
    en = 1'b0;
    step();
    n_checks++;
    if ({o_valid, o_change, o_timeout, o_ratio, o_high} !== '0) begin
      n_errs++;
      $display("FAIL en_drop got=%h exp=0", got_vec());
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (got_vec() !== exp_vec()) begin
        n_errs++;
        $display("FAIL en_low_cycle cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
      end
    end
    en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      n_checks++;
      if (got_vec() !== exp_vec()) begin
        n_errs++;
        $display("FAIL en_relock_cycle cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
      end
    end
    n_checks++;
    if ({o_valid, o_ratio, o_high} !== {1'b1, 8'd4, 8'd2}) begin
      n_errs++;
      $display("FAIL en_relock_values valid=%b ratio=%0d high=%0d exp 1/4/2", o_valid, o_ratio, o_high);
    end
  endtask

  task automatic test_random();
    int per;
    int high;
    int n;
    int sel;
    for (int seg = 0; seg < 14; seg++) begin
      per  = $urandom_range(40, 2);
      high = $urandom_range(per - 1, 1);
      sel  = $urandom_range(9, 0);
      if (sel < 2) begin
        en = 1'b0;
        n = $urandom_range(5, 1);
        for (int i = 0; i < n; i++) step();
      end else if (sel == 2) begin
        gen_periodic = 1'b0;
        gen_level = 1'($urandom_range(1, 0));
        n = $urandom_range(30, 5);
        for (int i = 0; i < n; i++) step();
      end
      en = 1'b1;
      if (sel > 6) begin
        gen_periodic = 1'b1;
        gen_per = per;
        gen_high = high;
        if (gen_ph >= per) gen_ph = 0;
      end else begin
        start_clock(per, high);
      end
      n = $urandom_range(6 * per + 10, 3 * per);
      for (int i = 0; i < n; i++) begin
        step();
        n_checks++;
        if (got_vec() !== exp_vec()) begin
          n_errs++;
          $display("FAIL random_cycle seg=%0d per=%0d high=%0d got=%h exp=%h",
                   seg, per, high, got_vec(), exp_vec());
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock_basic();
    test_ratio_switch();
    test_timeout_recover();
    test_boundary();
    test_bypass();
    test_reset_mid();
    test_enable_drop();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
